// File: rtl/score_display_pkg.sv
// score_display_pkg
//   Shared types and constants for the score_display block:
//   - state_t       : conversion FSM states (IDLE, SHIFT, UPDATE)
//   - SEG_D0..D9    : active-high 7-segment patterns, bit 0 = seg a .. bit 6 = seg g
//   - SEG_BLANK     : all segments off (active-high)
//   - pow10         : elaboration-time 10^n
//   - ovf_possible  : whether a BIN_W-bit value can exceed 10^DIGITS-1
package score_display_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2
  } state_t;

  localparam logic [6:0] SEG_D0    = 7'h3F;
  localparam logic [6:0] SEG_D1    = 7'h06;
  localparam logic [6:0] SEG_D2    = 7'h5B;
  localparam logic [6:0] SEG_D3    = 7'h4F;
  localparam logic [6:0] SEG_D4    = 7'h66;
  localparam logic [6:0] SEG_D5    = 7'h6D;
  localparam logic [6:0] SEG_D6    = 7'h7D;
  localparam logic [6:0] SEG_D7    = 7'h07;
  localparam logic [6:0] SEG_D8    = 7'h7F;
  localparam logic [6:0] SEG_D9    = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  // 2^40 already exceeds 10^8, the largest supported DIGITS, so wide inputs
  // can always overflow and the 64-bit shift below never saturates.
  function automatic bit ovf_possible(input int bin_w, input int digits);
    if (bin_w >= 40) begin
      return 1'b1;
    end
    return pow10(digits) <= ((64'd1 << bin_w) - 64'd1);
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// seg7_encode
//   Combinational BCD digit to 7-segment encoder.
//   Ports:
//     bcd   in  4  BCD digit (10..15 decode to blank)
//     blank in  1  force the digit blank
//     seg   out 7  segments, bit 0 = a .. bit 6 = g, polarity per SEG_ACTIVE_LOW
module seg7_encode
  import score_display_pkg::*;
#(
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  logic [6:0] pat;

  always_comb begin
    pat = SEG_BLANK;
    case (bcd)
      4'd0:    pat = SEG_D0;
      4'd1:    pat = SEG_D1;
      4'd2:    pat = SEG_D2;
      4'd3:    pat = SEG_D3;
      4'd4:    pat = SEG_D4;
      4'd5:    pat = SEG_D5;
      4'd6:    pat = SEG_D6;
      4'd7:    pat = SEG_D7;
      4'd8:    pat = SEG_D8;
      4'd9:    pat = SEG_D9;
      default: pat = SEG_BLANK;
    endcase
    if (blank) begin
      pat = SEG_BLANK;
    end
    seg = (SEG_ACTIVE_LOW != 0) ? ~pat : pat;
  end

endmodule

// File: rtl/score_display.sv
// score_display
//   Sequential binary-score to BCD / 7-segment driver. An iterative
//   double-dabble engine converts one bit per cycle behind a load/busy/done
//   handshake; the last completed result is held on registered outputs.
//   Scores above 10^DIGITS-1 saturate to all nines and raise overflow.
//   Optional build macro: SCORE_DISPLAY_LZ_BLANK_EN blanks leading-zero
//   digits on seg_out (digit 0 always shown); bcd_out is unaffected.
//   Ports:
//     clk      in   1         system clock
//     rst      in   1         asynchronous reset, active-low
//     bin_in   in   BIN_W     binary score, sampled on an accepted load
//     load     in   1         request a conversion (ignored while busy)
//     busy     out  1         conversion in progress
//     done     out  1         one-cycle pulse when bcd_out/seg_out update
//     overflow out  1         last accepted score exceeded 10^DIGITS-1
//     bcd_out  out  4*DIGITS  BCD result, digit 0 in [3:0]
//     seg_out  out  7*DIGITS  segments, digit k in [7k+6:7k]
module score_display
  import score_display_pkg::*;
#(
  parameter int BIN_W          = 20,
  parameter int DIGITS         = 6,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  load,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [7*DIGITS-1:0]   seg_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SEG_W = 7 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  // Overflow compare is only built when a BIN_W-bit value can exceed the
  // display range; otherwise it folds to constant 0.
  localparam bit               OVF_POSSIBLE = ovf_possible(BIN_W, DIGITS);
  localparam logic [BIN_W-1:0] MAX_BIN      =
    OVF_POSSIBLE ? BIN_W'(pow10(DIGITS) - 64'd1) : '0;

  function automatic logic [SEG_W-1:0] seg_reset_val();
    logic [6:0]       zero_p;
    logic [6:0]       blank_p;
    logic [SEG_W-1:0] v;
    zero_p  = (SEG_ACTIVE_LOW != 0) ? ~SEG_D0 : SEG_D0;
    blank_p = (SEG_ACTIVE_LOW != 0) ? ~SEG_BLANK : SEG_BLANK;
    v = '0;
    for (int k = 0; k < DIGITS; k++) begin
      v[7*k +: 7] = zero_p;
`ifdef SCORE_DISPLAY_LZ_BLANK_EN
      if (k > 0) begin
        v[7*k +: 7] = blank_p;
      end
`endif
    end
    return v;
  endfunction

  localparam logic [SEG_W-1:0] SEG_RST = seg_reset_val();

  state_t            state;
  state_t            next_state;
  logic [CNT_W-1:0]  cnt;
  logic              cap;
  logic              shift_en;
  logic              upd;

  logic [BIN_W-1:0]  bin_sr;
  logic [BCD_W-1:0]  bcd_work;
  logic [BCD_W-1:0]  bcd_adj;
  logic              ovf_cap;
  logic              ovf_nxt;

  logic [BCD_W-1:0]  res_bcd;
  logic [DIGITS-1:0] blank;
  logic [SEG_W-1:0]  seg_enc;

  assign busy    = (state != IDLE);
  assign ovf_nxt = OVF_POSSIBLE && (bin_in > MAX_BIN);
  assign res_bcd = ovf_cap ? {DIGITS{4'h9}} : bcd_work;

  always_comb begin
    next_state = state;
    cap        = 1'b0;
    shift_en   = 1'b0;
    upd        = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          cap        = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt == CNT_W'(1)) begin
          next_state = UPDATE;
        end
      end
      UPDATE: begin
        upd        = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Double-dabble correction: any digit >= 5 would carry past 9 once
  // doubled, so pre-add 3 before the shift.
  always_comb begin
    bcd_adj = bcd_work;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_work[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_work[4*k +: 4] + 4'd3;
      end
    end
  end

  // Leading-zero blanking on the value about to be committed.
  always_comb begin
    blank = '0;
`ifdef SCORE_DISPLAY_LZ_BLANK_EN
    begin
      logic lz;
      lz = 1'b1;
      for (int k = DIGITS - 1; k >= 1; k--) begin
        lz       = lz & (res_bcd[4*k +: 4] == 4'd0);
        blank[k] = lz;
      end
    end
`endif
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_enc
    seg7_encode #(
      .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
    ) u_enc (
      .bcd  (res_bcd[4*g +: 4]),
      .blank(blank[g]),
      .seg  (seg_enc[7*g +: 7])
    );
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
      bcd_out  <= '0;
      seg_out  <= SEG_RST;
    end else begin
      state <= next_state;
      done  <= upd;
      if (cap) begin
        cnt <= CNT_W'(BIN_W);
      end else if (shift_en) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (upd) begin
        bcd_out  <= res_bcd;
        seg_out  <= seg_enc;
        overflow <= ovf_cap;
      end
    end
  end

  // Conversion datapath; no reset needed, always initialised by a load.
  always_ff @(posedge clk) begin
    if (cap) begin
      bin_sr   <= bin_in;
      bcd_work <= '0;
      ovf_cap  <= ovf_nxt;
    end else if (shift_en) begin
      bin_sr   <= {bin_sr[BIN_W-2:0], 1'b0};
      bcd_work <= {bcd_adj[BCD_W-2:0], bin_sr[BIN_W-1]};
    end
  end

endmodule

// File: tb/tb_score_display.sv
module tb_score_display;

  logic        clk;
  logic        rst;
  logic [19:0] bin_in;
  logic        load;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [23:0] bcd_out;
  logic [41:0] seg_out;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [19:0] bin;
    logic [23:0] bcd;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [23:0] bcd;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[10];

  score_display #(
    .BIN_W(20),
    .DIGITS(6),
    .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bin_in  (bin_in),
    .load    (load),
    .busy    (busy),
    .done    (done),
    .overflow(overflow),
    .bcd_out (bcd_out),
    .seg_out (seg_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Independent segment model: active-low board patterns.
  function automatic logic [41:0] seg_model(input logic [23:0] b);
    logic [41:0] r;
    logic [6:0]  p;
    logic [3:0]  d;
`ifdef SCORE_DISPLAY_LZ_BLANK_EN
    logic        lz;
    lz = 1'b1;
`endif
    r = '0;
    for (int k = 5; k >= 0; k--) begin
      d = b[4*k +: 4];
      case (d)
        4'd0: p = 7'b0111111;
        4'd1: p = 7'b0000110;
        4'd2: p = 7'b1011011;
        4'd3: p = 7'b1001111;
        4'd4: p = 7'b1100110;
        4'd5: p = 7'b1101101;
        4'd6: p = 7'b1111101;
        4'd7: p = 7'b0000111;
        4'd8: p = 7'b1111111;
        4'd9: p = 7'b1101111;
        default: p = 7'b0000000;
      endcase
`ifdef SCORE_DISPLAY_LZ_BLANK_EN
      if (k > 0) begin
        lz = lz && (d == 4'd0);
        if (lz) p = 7'b0000000;
      end
`endif
      r[7*k +: 7] = ~p;
    end
    return r;
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst && done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got bcd %0h expected no done pulse", bcd_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_bcd", 64'(bcd_out), 64'(e.bcd));
        chk("sb_ovf", 64'(overflow), 64'(e.ovf));
        chk("sb_seg", 64'(seg_out), 64'(seg_model(e.bcd)));
        chk("sb_busy_low", 64'(busy), 64'd0);
      end
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL idle_wait: got busy=1 expected busy=0 within 50 cycles");
    end
  endtask

  task automatic do_conv(input logic [19:0] v, input logic [23:0] eb, input logic eo);
    int  lat;
    bit  seen;
    wait_idle();
    bin_in = v;
    load   = 1'b1;
    @(posedge clk);
    sb.push_back('{bcd: eb, ovf: eo});
    #1;
    load   = 1'b0;
    bin_in = 20'($urandom);
    chk("busy_after_load", 64'(busy), 64'd1);
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        lat  = k;
        break;
      end
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done expected done after 21 cycles");
    end else begin
      chk("latency", 64'(lat), 64'd21);
    end
  endtask

  initial begin
    int  d;
    bit  seen;

    vecs[0] = '{bin: 20'd123456,  bcd: 24'h123456, ovf: 1'b0};
    vecs[1] = '{bin: 20'd0,       bcd: 24'h000000, ovf: 1'b0};
    vecs[2] = '{bin: 20'd999999,  bcd: 24'h999999, ovf: 1'b0};
    vecs[3] = '{bin: 20'd1000000, bcd: 24'h999999, ovf: 1'b1};
    vecs[4] = '{bin: 20'd1048575, bcd: 24'h999999, ovf: 1'b1};
    vecs[5] = '{bin: 20'd5,       bcd: 24'h000005, ovf: 1'b0};
    vecs[6] = '{bin: 20'd42,      bcd: 24'h000042, ovf: 1'b0};
    vecs[7] = '{bin: 20'd100001,  bcd: 24'h100001, ovf: 1'b0};
    vecs[8] = '{bin: 20'd90817,   bcd: 24'h090817, ovf: 1'b0};
    vecs[9] = '{bin: 20'd10,      bcd: 24'h000010, ovf: 1'b0};

    rst    = 1'b0;
    load   = 1'b0;
    bin_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_bcd", 64'(bcd_out), 64'd0);
    chk("rst_seg", 64'(seg_out), 64'(seg_model(24'h000000)));
    @(negedge clk);
    rst = 1'b1;

    // Table-driven conversions.
    for (int i = 0; i < 10; i++) begin
      do_conv(vecs[i].bin, vecs[i].bcd, vecs[i].ovf);
      if (i == 0) begin
        #2;
        chk("seg_digit5_is_1", 64'(seg_out[41:35]), 64'(7'b1111001));
      end
    end

    // Back-to-back with load held high: 0 then 999999, 22 cycles apart.
    wait_idle();
    bin_in = 20'd0;
    load   = 1'b1;
    @(posedge clk);
    sb.push_back('{bcd: 24'h000000, ovf: 1'b0});
    sb.push_back('{bcd: 24'h999999, ovf: 1'b0});
    #1;
    bin_in = 20'd999999;
    seen = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin seen = 1'b1; break; end
    end
    chk("b2b_first_done", 64'(seen), 64'd1);
    @(posedge clk); #1;
    load = 1'b0;
    d    = 1;
    seen = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      d++;
      if (done) begin seen = 1'b1; break; end
    end
    chk("b2b_second_done", 64'(seen), 64'd1);
    chk("b2b_period", 64'(d), 64'd22);

    // Load while busy is ignored; busy stays high until done.
    wait_idle();
    bin_in = 20'd42;
    load   = 1'b1;
    @(posedge clk);
    sb.push_back('{bcd: 24'h000042, ovf: 1'b0});
    #1;
    load = 1'b0;
    seen = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 5) begin bin_in = 20'd777; load = 1'b1; end
      if (k == 6) load = 1'b0;
      if (done) begin seen = 1'b1; break; end
      chk("busy_held", 64'(busy), 64'd1);
    end
    chk("ignored_load_done", 64'(seen), 64'd1);
    repeat (25) @(posedge clk);
    #1;
    chk("ignored_load_idle", 64'(busy), 64'd0);

    // Reset mid-conversion aborts with no done pulse.
    bin_in = 20'd500000;
    load   = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_bcd", 64'(bcd_out), 64'd0);
    chk("abort_ovf", 64'(overflow), 64'd0);
    chk("abort_seg", 64'(seg_out), 64'(seg_model(24'h000000)));
    @(negedge clk);
    rst = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    chk("abort_stay_idle", 64'(busy), 64'd0);
    chk("abort_bcd_hold", 64'(bcd_out), 64'd0);
    do_conv(20'd7, 24'h000007, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/score_display.md
Name: score_display

Overview:
- Sequential, parametrised score-to-7-segment driver; successor to the fixed 20-bit/6-digit combinational converter path.
- Converts a BIN_W-bit binary score to DIGITS BCD digits with an iterative double-dabble engine (one bit per cycle), behind a load/busy/done handshake.
- Holds the last completed result on registered 7-segment outputs, so the display never flickers mid-conversion.
- Saturates out-of-range scores to all nines and flags overflow; sits between game-score logic and the board HEX displays.

Parameters:
- BIN_W, 20, width of the binary score input (>= 4).
- DIGITS, 6, number of BCD digits and 7-seg displays driven (1..8).
- SEG_ACTIVE_LOW, 1, 1 = segment on is driven 0 (board HEX); 0 = segment on is driven 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low (0 = reset)
- bin_in  in  BIN_W  binary score; sampled only on an accepted load
- load  in  1  request conversion of bin_in
- busy  out  1  conversion in progress; load ignored while high
- done  out  1  one-cycle pulse when bcd_out/seg_out update
- overflow  out  1  last accepted bin_in > 10^DIGITS-1; held until next update
- bcd_out  out  4*DIGITS  registered BCD result, digit 0 in [3:0]
- seg_out  out  7*DIGITS  registered segments, digit k in [7k+6:7k], bit 0 = seg a .. bit 6 = seg g

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; busy=0, done=0, overflow=0, bcd_out=0; seg_out shows "0" on every digit (subject to the optional feature); shift counter=0.
- States: IDLE, SHIFT, UPDATE.
- IDLE: load=1 captures bin_in into the binary shift register, clears the BCD work register, loads counter=BIN_W, registers the overflow compare (bin_in > MAX, MAX = 10^DIGITS-1 computed at elaboration; constant 0 when 10^DIGITS > 2^BIN_W-1), and moves to SHIFT; busy=1 from the next cycle.
- SHIFT: each cycle, add 3 to every BCD digit >= 5, then shift {bcd, bin} left by 1 in the same cycle. Decrement the counter and go to UPDATE once it reaches 0, i.e. after exactly BIN_W shift cycles.
- UPDATE: bcd_out is set to the work register, or to all 4'h9 if overflow. seg_out is re-encoded from that value, overflow is set from the captured flag, done=1 for this cycle only, busy=0 at the next edge, then return to IDLE.
- Latency: load accepted at edge N; done high and outputs valid in cycle N+BIN_W+1; a new load is accepted in the cycle after done.
- load while busy: ignored, no queuing. load held high continuously: back-to-back conversions, each with period BIN_W+2.
- Outputs hold their previous values throughout SHIFT.
- Reset mid-conversion: aborts immediately; outputs return to reset values and no done pulse is issued.
- BCD work register overflow during shifting of an out-of-range input is harmless; the result is replaced by saturation.
- Segment code: 0-9 standard patterns. Nibble values 10-15 map to blank (unreachable; defensive). Polarity is inverted when SEG_ACTIVE_LOW=1.

Optional Feature:
- Macro: SCORE_DISPLAY_LZ_BLANK_EN.
- Defined: leading-zero digits, from the most significant digit down to the first nonzero digit, are driven blank on seg_out. Digit 0 is never blanked. bcd_out is unaffected. Blanking is evaluated in UPDATE and at reset, so reset shows only digit 0 as "0".
- Undefined: all DIGITS digits are always displayed, including leading zeros.

Decomposition:
- Package score_display_pkg holds:
  - state enum (IDLE, SHIFT, UPDATE)
  - 7-bit active-high segment constants for 0-9 and SEG_BLANK
  - constant function pow10 for MAX
- Sub-module seg7_encode: combinational; 4-bit bcd in, blank in, SEG_ACTIVE_LOW parameter, 7-bit seg out. Instantiated DIGITS times via generate; its outputs are registered in score_display.

Test Plan:
- Default params, load bin_in=123456 -> done exactly BIN_W+1=21 cycles after the load edge; bcd_out=24'h123456; overflow=0; seg digit 5 = "1" pattern, active-low (7'b1111001).
- bin_in=0 then bin_in=999999 back-to-back (load held high) -> bcd_out=24'h000000, then 24'h999999 exactly 22 cycles later.
- bin_in=1000000, then 1048575 -> overflow=1, bcd_out=24'h999999 for both; a following 5 -> overflow=0, bcd_out=24'h000005.
- Load 42; at cycle 5 pulse load with 777 -> second load ignored; result 24'h000042; busy stays high throughout.
- Load 500000; assert rst=0 at cycle 10 -> no done pulse; bcd_out=0, busy=0; the next load of 7 converts correctly.
- With SCORE_DISPLAY_LZ_BLANK_EN, bin_in=42 -> digits 5..2 blank (7'b1111111), digit 1 = "4", digit 0 = "2"; bin_in=0 -> only digit 0 shows "0".
